// File: rtl/ahb_ram_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing the single-port AHB RAM
// slave between instruction fetch (requester 0) and the load/store unit (requester 1).
module ahb_ram_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter bit          RST_PRIO    = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [15:0] m0_addr,
  input  logic [2:0]  m0_rwtyp,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [15:0] m1_addr,
  input  logic [2:0]  m1_rwtyp,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        hsel,
  output logic        hwrite,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic        grant_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        last;
  logic        req_any;
  logic        sel;
  logic        sel_write;
  logic [15:0] sel_addr;
  logic [2:0]  sel_rwtyp;
  logic [31:0] sel_wdata;
  logic        done;
  logic        resp_err;
  logic [31:0] resp_data;
  logic        unused_hresp;

  assign unused_hresp = hresp;

  // When both request, the one not granted last wins; `last` starts as ~RST_PRIO.
  always_comb begin
    req_any   = m0_req | m1_req;
    sel       = (m0_req & m1_req) ? ~last : m1_req;
    sel_write = sel ? m1_write : m0_write;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_rwtyp = sel ? m1_rwtyp : m0_rwtyp;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    done      = hready | (cnt == TO_LAST);
    resp_err  = ~hready;
    resp_data = (hready && !hwrite) ? hrdata : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= ~RST_PRIO;
      grant_id <= 1'b0;
      busy     <= 1'b0;
      hsel     <= 1'b0;
      hwrite   <= 1'b0;
      haddr    <= '0;
      hwdata   <= '0;
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
    end else begin
      // Response outputs are pulses: live only during the RESP cycle.
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= '0;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state    <= BUSY;
            cnt      <= '0;
            busy     <= 1'b1;
            hsel     <= 1'b1;
            grant_id <= sel;
            last     <= sel;
            hwrite   <= sel_write;
            haddr    <= {2'b00, sel_rwtyp, 11'b0, sel_addr};
            hwdata   <= sel_wdata;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (done) begin
            state <= RESP;
            hsel  <= 1'b0;
            if (grant_id) begin
              m1_ack   <= 1'b1;
              m1_err   <= resp_err;
              m1_rdata <= resp_data;
            end else begin
              m0_ack   <= 1'b1;
              m0_err   <= resp_err;
              m0_rdata <= resp_data;
            end
          end
        end
        RESP: state <= GAP;
        GAP: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_ram_arbiter.sv
// Directed self-checking bench for ahb_ram_arbiter: the tb drives hready/hrdata as the slave.
module tb_ahb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_req = 1'b0, m0_write = 1'b0;
  logic [15:0] m0_addr = '0;
  logic [2:0]  m0_rwtyp = '0;
  logic [31:0] m0_wdata = '0;
  logic        m0_ack, m0_err;
  logic [31:0] m0_rdata;
  logic        m1_req = 1'b0, m1_write = 1'b0;
  logic [15:0] m1_addr = '0;
  logic [2:0]  m1_rwtyp = '0;
  logic [31:0] m1_wdata = '0;
  logic        m1_ack, m1_err;
  logic [31:0] m1_rdata;
  logic        hsel, hwrite;
  logic [31:0] haddr, hwdata;
  logic        hready = 1'b0, hresp = 1'b0;
  logic [31:0] hrdata = '0;
  logic        grant_id, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ahb_ram_arbiter #(.TIMEOUT_CYC(16), .RST_PRIO(1'b0)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_rwtyp(m0_rwtyp),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_rwtyp(m1_rwtyp),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic txn(input logic id, input logic wr, input logic [15:0] addr,
                     input logic [2:0] typ, input logic [31:0] wd,
                     input int unsigned ready_at, input logic [31:0] srd,
                     input logic [31:0] exp_haddr, input int unsigned exp_busy,
                     input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int unsigned n;
    logic stable;
    if (id) begin
      m1_req = 1'b1; m1_write = wr; m1_addr = addr; m1_rwtyp = typ; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_write = wr; m0_addr = addr; m0_rwtyp = typ; m0_wdata = wd;
    end
    for (int i = 0; i < 20 && !hsel; i++) tick();
    check({tag, "_grant"}, 32'(hsel), 32'd1);
    check({tag, "_grant_id"}, 32'(grant_id), 32'(id));
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_hwrite"}, 32'(hwrite), 32'(wr));
    check({tag, "_haddr"}, haddr, exp_haddr);
    if (wr) check({tag, "_hwdata"}, hwdata, wd);
    n = 0;
    stable = 1'b1;
    while (hsel && !m0_ack && !m1_ack && n < 40) begin
      n++;
      if (haddr !== exp_haddr || hwrite !== wr || (wr && hwdata !== wd)) stable = 1'b0;
      if (n == ready_at) begin
        hready = 1'b1;
        hrdata = srd;
      end
      tick();
      hready = 1'b0;
      hrdata = '0;
    end
    check({tag, "_busy_cycles"}, n, exp_busy);
    check({tag, "_stable"}, 32'(stable), 32'd1);
    check({tag, "_resp_hsel"}, 32'(hsel), 32'd0);
    check({tag, "_ack"}, 32'(id ? m1_ack : m0_ack), 32'd1);
    check({tag, "_other_ack"}, 32'(id ? m0_ack : m1_ack), 32'd0);
    check({tag, "_err"}, 32'(id ? m1_err : m0_err), 32'(exp_err));
    check({tag, "_rdata"}, id ? m1_rdata : m0_rdata, exp_rd);
    check({tag, "_other_rdata"}, id ? m0_rdata : m1_rdata, 32'd0);
    if (id) m1_req = 1'b0; else m0_req = 1'b0;
    tick();
    check({tag, "_gap_ack"}, 32'({m0_ack, m1_ack}), 32'd0);
    check({tag, "_gap_hsel"}, 32'(hsel), 32'd0);
    tick();
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int unsigned low;
    logic owner;

    // Reset state
    tick(); tick();
    check("rst_hsel", 32'(hsel), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
    check("rst_haddr", haddr, 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    rstn = 1'b1;
    tick();

    // Contested requests held across four transactions: expect 0,1,0,1
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 16'h0020; m0_rwtyp = 3'b001;
    m1_req = 1'b1; m1_write = 1'b0; m1_addr = 16'h0030; m1_rwtyp = 3'b100;
    low = 0;
    for (int k = 0; k < 4; k++) begin
      owner = k[0];
      for (int i = 0; i < 20 && !hsel; i++) begin
        tick();
        low++;
      end
      if (k > 0) check("rr_gap_low", 32'(low >= 2), 32'd1);
      check("rr_grant", 32'(hsel), 32'd1);
      check("rr_grant_id", 32'(grant_id), 32'(owner));
      check("rr_haddr", haddr, owner ? 32'h2000_0030 : 32'h0800_0020);
      hready = 1'b1;
      hrdata = 32'h0000_1000 + 32'(k);
      tick();
      hready = 1'b0;
      hrdata = '0;
      check("rr_ack_owner", 32'(owner ? m1_ack : m0_ack), 32'd1);
      check("rr_ack_other", 32'(owner ? m0_ack : m1_ack), 32'd0);
      check("rr_rdata", owner ? m1_rdata : m0_rdata, 32'h0000_1000 + 32'(k));
      low = 1;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    tick(); tick(); tick();
    check("rr_idle_busy", 32'(busy), 32'd0);

    // Single read, single write
    txn(1'b0, 1'b0, 16'h0010, 3'b010, 32'h0, 2, 32'hDEAD_BEEF,
        32'h1000_0010, 2, 1'b0, 32'hDEAD_BEEF, "rd0");
    txn(1'b1, 1'b1, 16'h0100, 3'b000, 32'h1234_5678, 2, 32'hFFFF_FFFF,
        32'h0000_0100, 2, 1'b0, 32'h0, "wr1");

    // Watchdog timeout, then a normal m1 read
    txn(1'b0, 1'b0, 16'h0040, 3'b010, 32'h0, 0, 32'h0,
        32'h1000_0040, 16, 1'b1, 32'h0, "tmo");
    txn(1'b1, 1'b0, 16'h0044, 3'b010, 32'h0, 1, 32'hCAFE_F00D,
        32'h1000_0044, 1, 1'b0, 32'hCAFE_F00D, "after_tmo");

    // hready coincides with the timeout cycle
    txn(1'b0, 1'b0, 16'h0050, 3'b001, 32'h0, 16, 32'h0BAD_F00D,
        32'h0800_0050, 16, 1'b0, 32'h0BAD_F00D, "coincide");

    // Asynchronous reset mid-BUSY
    m0_req = 1'b1; m0_write = 1'b0; m0_addr = 16'h0070; m0_rwtyp = 3'b010;
    tick();
    check("arst_pre_hsel", 32'(hsel), 32'd1);
    tick(); tick();
    #2 rstn = 1'b0;
    #1;
    check("arst_hsel", 32'(hsel), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_acks", 32'({m0_ack, m1_ack}), 32'd0);
    m0_req = 1'b0;
    tick();
    rstn = 1'b1;
    low = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m0_ack || m1_ack || hsel) low++;
    end
    check("arst_no_ack", low, 32'd0);
    txn(1'b1, 1'b1, 16'h0060, 3'b000, 32'hA5A5_A5A5, 3, 32'h0,
        32'h0000_0060, 3, 1'b0, 32'h0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_ram_arbiter.md
Name: ahb_ram_arbiter

Overview:
- Two-port arbiter and transaction sequencer in front of the single-port AHB RAM slave in the riscv32 system.
- Shares the slave between requester 0 (instruction fetch) and requester 1 (load/store unit) using round-robin arbitration.
- Packs the address/type fields, holds the bus stable until the slave signals hready, and returns read data with a one-cycle ack.
- A watchdog timeout converts a hung slave transaction into an error response.

Parameters:
- TIMEOUT_CYC, 16: cycles allowed in BUSY without hready before the transaction is aborted with error; range 2..255.
- RST_PRIO, 0: requester index favoured on the first contested grant after reset.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- m0_req  in  1  requester 0 transaction request, held until m0_ack
- m0_write  in  1  1 = write, 0 = read
- m0_addr  in  16  RAM byte address
- m0_rwtyp  in  3  access type/size code
- m0_wdata  in  32  write data
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  valid with m0_ack; 1 = timeout
- m0_rdata  out  32  read data, valid with m0_ack
- m1_req, m1_write, m1_addr, m1_rwtyp, m1_wdata, m1_ack, m1_err, m1_rdata: same definitions for requester 1
- hsel  out  1  slave select
- hwrite  out  1  slave write strobe
- haddr  out  32  {2'b00, rwtyp[2:0], 11'b0, addr[15:0]}
- hwdata  out  32  slave write data
- hready  in  1  slave completion
- hresp  in  1  ignored; reserved
- hrdata  in  32  slave read data
- grant_id  out  1  index of the current/last granted requester (debug)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0. State IDLE, timeout counter 0, round-robin pointer set so RST_PRIO wins the first contested grant.
- States: IDLE, BUSY, RESP, GAP.
- IDLE:
  - No request: remain in IDLE.
  - One request: grant it.
  - Both requesting: grant the one not granted last (round-robin).
  - On grant: latch write/addr/rwtyp/wdata and the grant index into internal registers, update the pointer, go to BUSY.
  - hsel stays 0 during IDLE.
- BUSY:
  - hsel=1; hwrite, haddr, hwdata driven from the latched registers and held constant for the whole state.
  - Counter increments each cycle.
  - hready=1: capture hrdata, clear err, go to RESP.
  - Else, counter reaches TIMEOUT_CYC-1: capture rdata=0, err=1, go to RESP.
  - hready and timeout in the same cycle: hready wins, err=0.
- RESP:
  - hsel=0. Granted requester sees ack=1 for exactly one cycle with rdata/err.
  - The other requester's ack, err and rdata stay 0. rdata is 0 on writes.
  - Next state GAP.
- GAP:
  - hsel=0 for one cycle so the slave returns to idle. Counter cleared, then IDLE.
  - Minimum request-to-request spacing is 4 cycles (IDLE, BUSY ≥1, RESP, GAP).
- Latency, grant to ack: 1 cycle (IDLE) + BUSY cycles + 1 cycle.
- Requester changes or drops req while granted: no effect, because fields were latched at grant. A dropped req still receives its ack pulse.
- A requester that keeps req high after its ack is a new request. It loses to the other requester if both are pending (no starvation).
- hsel never asserts in the cycle immediately following RESP.
- rstn asserted mid-transaction: asynchronous return to reset values. In-flight transaction dropped with no ack; hsel falls immediately.
- grant_id updates at grant and holds until the next grant.

Test Plan:
- Single read: m0 read addr 0x0010, rwtyp 3'b010; slave hready after 2 BUSY cycles with hrdata 0xDEADBEEF.
  - haddr = 0x10000010, hwrite=0.
  - m0_ack pulses with m0_rdata 0xDEADBEEF, m0_err=0.
- Single write: m1 write addr 0x0100, wdata 0x12345678, rwtyp 3'b000.
  - hwrite=1, hwdata 0x12345678, haddr 0x00000100 stable until hready.
  - m1_ack pulses with m1_rdata 0.
- Simultaneous requests held continuously for 4 transactions after reset (RST_PRIO=0):
  - Grants occur in order 0,1,0,1.
  - Each ack goes only to its owner; hsel is low ≥2 cycles between transactions.
- Timeout: hready tied 0, m0 read.
  - hsel high exactly 16 cycles, then m0_ack=1, m0_err=1, m0_rdata=0.
  - A subsequent m1 request completes normally.
- hready arrives on the 16th BUSY cycle, coinciding with timeout: ack with err=0 and captured hrdata.
- rstn pulsed low mid-BUSY:
  - hsel, acks and busy go 0 immediately; no ack for the aborted transaction.
  - After release, a new m1 request is granted and completes.
